// File: rtl/sub4_seq.sv
// sub4_seq -- sequential subtractor, DIFF = A - B - Bin, one SLICE-bit slice
// per clock, LSB slice first, with the borrow carried in a register.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake (in_ready high only in IDLE)
//   A, B, Bin           minuend, subtrahend, borrow in (sampled on accept)
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   DIFF, Bout          registered result and final borrow
module sub4_seq #(
    parameter int WIDTH = 4,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] DIFF,
    output logic             Bout
);

    localparam int NSL = WIDTH / SLICE;
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE:0]   w_sub;
    logic             w_last;

    // Current slice operands; borrow only comes from the register, so there
    // is no combinational ripple between slices.
    assign w_a_sl = r_a[r_k*SLICE +: SLICE];
    assign w_b_sl = r_b[r_k*SLICE +: SLICE];
    // One extra bit: a negative slice result wraps so its MSB is the borrow.
    assign w_sub  = {1'b0, w_a_sl} - {1'b0, w_b_sl} - {{SLICE{1'b0}}, r_borrow};
    assign w_last = (r_k == KW'(NSL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_k      <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= Bin;
                        r_k      <= '0;
                        r_diff   <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_diff[r_k*SLICE +: SLICE] <= w_sub[SLICE-1:0];
                    r_borrow                   <= w_sub[SLICE];
                    r_k                        <= r_k + 1'b1;
                    if (w_last) begin
                        r_bout  <= w_sub[SLICE];
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake flags come straight from state: no input-to-output path.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign DIFF      = r_diff;
    assign Bout      = r_bout;

endmodule

// File: tb/tb_sub4_seq.sv
`timescale 1ns/1ps
module tb_sub4_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic       Bin;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] DIFF;
    logic       Bout;

    int checks = 0;
    int errors = 0;

    sub4_seq #(.WIDTH(4), .SLICE(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Bin(Bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .DIFF(DIFF), .Bout(Bout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] ed;
        logic       eb;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, wrapped to 4 bits.
    function automatic logic [3:0] ref_diff(input int a, input int b, input int bin);
        int d;
        d = a - b - bin;
        return 4'(((d % 16) + 16) % 16);
    endfunction

    function automatic logic ref_bout(input int a, input int b, input int bin);
        return (a < b + bin);
    endfunction

    // One full transaction; stall = cycles out_ready stays low once DONE.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                          input logic [3:0] ed, input logic eb, input int stall,
                          input string tag, output time t_acc);
        int n;
        @(negedge clk);
        chk({tag, " in_ready"}, int'(in_ready), 1);
        A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = (stall == 0);
        @(posedge clk);
        t_acc = $time;
        #1;
        in_valid = 1'b0;
        A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 8);
        chk({tag, " latency"}, n, 3);
        chk({tag, " DIFF"}, int'(DIFF), int'(ed));
        chk({tag, " Bout"}, int'(Bout), int'(eb));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, " hold DIFF"}, int'(DIFF), int'(ed));
            chk({tag, " hold out_valid"}, int'(out_valid), 1);
            chk({tag, " hold in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " release in_ready"}, int'(in_ready), 1);
        chk({tag, " release out_valid"}, int'(out_valid), 0);
    endtask

    initial begin
        vec_t tbl[8];
        time  t, tprev;
        int   a, b, bin, n;

        tbl[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
        tbl[1] = '{4'd3,  4'd9,  1'b0, 4'hA,  1'b1};
        tbl[2] = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1};
        tbl[3] = '{4'd4,  4'd1,  1'b0, 4'd3,  1'b0};
        tbl[4] = '{4'd7,  4'd7,  1'b0, 4'd0,  1'b0};
        tbl[5] = '{4'd15, 4'd15, 1'b1, 4'hF,  1'b1};
        tbl[6] = '{4'd15, 4'd0,  1'b0, 4'hF,  1'b0};
        tbl[7] = '{4'd8,  4'd8,  1'b1, 4'hF,  1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset DIFF", int'(DIFF), 0);
        chk("reset Bout", int'(Bout), 0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].ed, tbl[i].eb, 0,
                   $sformatf("vec%0d", i), t);

        // Back-pressure with in_valid held and operands changing
        @(negedge clk);
        A = 4'd12; B = 4'd5; Bin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        A = 4'd1; B = 4'd14; Bin = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 8);
        chk("bp latency", n, 3);
        for (int s = 0; s < 5; s++) begin
            chk("bp DIFF", int'(DIFF), 6);
            chk("bp Bout", int'(Bout), 0);
            chk("bp in_ready", int'(in_ready), 0);
            chk("bp out_valid", int'(out_valid), 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", int'(in_ready), 1);
        chk("bp release out_valid", int'(out_valid), 0);
        in_valid = 1'b0;

        // Reset in the middle of RUN
        @(negedge clk);
        A = 4'd15; B = 4'd1; Bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst DIFF", int'(DIFF), 0);
        chk("midrst Bout", int'(Bout), 0);
        chk("midrst in_ready", int'(in_ready), 1);
        repeat (3) begin
            @(negedge clk);
            chk("midrst no out_valid", int'(out_valid), 0);
        end
        rst_n = 1'b1;
        run_op(4'd7, 4'd7, 1'b0, 4'd0, 1'b0, 0, "postrst", t);

        // Randomized with random stalls against the reference model
        for (int i = 0; i < 60; i++) begin
            a = int'($urandom_range(15)); b = int'($urandom_range(15));
            bin = int'($urandom_range(1));
            run_op(4'(a), 4'(b), 1'(bin), ref_diff(a, b, bin), ref_bout(a, b, bin),
                   int'($urandom_range(3)), "rand", t);
        end

        // Exhaustive back-to-back sweep, checking initiation interval
        tprev = 0;
        for (int i = 0; i < 512; i++) begin
            a = i & 15; b = (i >> 4) & 15; bin = (i >> 8) & 1;
            run_op(4'(a), 4'(b), 1'(bin), ref_diff(a, b, bin), ref_bout(a, b, bin),
                   0, "sweep", t);
            if (i > 0) chk("sweep II", int'((t - tprev) / 10), 4);
            tprev = t;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
